chunked_serial_adder: RTL

//  - Multi-cycle WIDTH-bit adder: sum/carry-out of a + b + cin, CHUNK bits per clock, LSB chunk first.
//  - Trades latency for area against the flat combinational full adders.
//  - Sits behind valid/ready handshakes on both sides; one operation in flight at a time.

---
 rtl/chunked_serial_adder_pkg.sv | 16 +
 rtl/chunked_serial_adder_chunk_adder.sv | 33 +++
 rtl/chunked_serial_adder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM state encoding and
// the chunk-counter width helper.
package chunked_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n chunks; a single-chunk configuration still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit adder slice: s = a + b + ci, co = carry out.
// With OVERFLOW_FLAG_EN defined it also exposes c_msb, the carry into the
// top bit of the slice, used for signed-overflow detection.
module chunk_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             c_msb
`endif
);

  logic [CHUNK:0] full;

  // Add the slice with one guard bit; the carry into the MSB is recovered
  // from the MSB sum bit and the two MSB operand bits.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    s     = full[CHUNK-1:0];
    co    = full[CHUNK];
`ifdef OVERFLOW_FLAG_EN
    c_msb = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
`endif
  end

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder computing a + b + cin CHUNK bits per clock,
// LSB chunk first, behind valid/ready handshakes with one operation in flight.
// Optional macro OVERFLOW_FLAG_EN adds the signed-overflow output ovf.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("chunked_serial_adder: illegal WIDTH/CHUNK combination");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
`ifdef OVERFLOW_FLAG_EN
  logic             chunk_c_msb;
  logic             ovf_q, ovf_d;
`endif

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a     (a_sh_q[CHUNK-1:0]),
    .b     (b_sh_q[CHUNK-1:0]),
    .ci    (carry_q),
    .s     (chunk_s),
    .co    (chunk_co)
`ifdef OVERFLOW_FLAG_EN
    ,
    .c_msb (chunk_c_msb)
`endif
  );

  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

  // Next-state and datapath: accept in IDLE, one chunk per cycle in RUN,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d       = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        // Each new chunk enters at the MSB end so after NCHUNK shifts the
        // first (LSB) chunk has arrived at bit 0.
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        carry_d = chunk_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          cout_d      = chunk_co;
`ifdef OVERFLOW_FLAG_EN
          ovf_d       = chunk_c_msb ^ chunk_co;
`endif
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule
